score4_panel_ctrl: RTL

Game-board writer for the Score4 (connect-four) design. Owns the 6x7 panel register and converts debounced column-button presses into piece drops, with a visible falling animation. Commits each piece, then samples the win/full flags from the combinational state checker. Alternates turns or freezes the game.

---
 rtl/score4_pkg.sv | 35 +++
 rtl/score4_land_row.sv | 18 +
 rtl/score4_panel_ctrl.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/score4_pkg.sv
// Shared types and helpers for the Score4 board writer.
package score4_pkg;

  localparam int ROWS = 6;
  localparam int COLS = 7;

  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    RED   = 2'b01,
    GREEN = 2'b10
  } cell_t;

  typedef enum logic [1:0] {
    IDLE,
    DROP,
    CHECK,
    OVER
  } state_t;

  typedef struct packed {
    logic       vld;
    logic [2:0] idx;
  } col_sel_t;

  // One-hot column vector to column index; vld is low for zero or multi-hot input.
  function automatic col_sel_t onehot_idx(input logic [COLS-1:0] v);
    col_sel_t s;
    s.vld = (v != '0) && ((v & (v - 7'd1)) == '0);
    s.idx = '0;
    for (int c = 0; c < COLS; c++)
      if (v[c]) s.idx = 3'(c);
    return s;
  endfunction

endpackage

// File: rtl/score4_land_row.sv
// Lowest empty row of one board column; row 0 is the bottom.
module score4_land_row
  import score4_pkg::*;
(
  input  logic [ROWS-1:0][1:0] cells,
  output logic [2:0]           row,
  output logic                 col_full
);

  // Scan top-down so the last empty cell seen is the lowest one.
  always_comb begin
    row = '0;
    for (int r = ROWS-1; r >= 0; r--)
      if (cells[r] == EMPTY) row = 3'(r);
    col_full = (cells[ROWS-1] != EMPTY);
  end

endmodule

// File: rtl/score4_panel_ctrl.sv
// Score4 board writer: press -> animated drop -> commit -> checker sample.
module score4_panel_ctrl
  import score4_pkg::*;
#(
  parameter int DROP_TICKS = 25000000
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [COLS-1:0]               play,
  input  logic                          new_game,
  input  logic                          win_a,
  input  logic                          win_b,
  input  logic                          full_panel,
  output logic [ROWS-1:0][COLS-1:0][1:0] panel,
  output logic                          turn,
  output logic                          busy,
  output logic                          game_over,
  output logic                          invalid
);

  localparam int TW = (DROP_TICKS > 1) ? $clog2(DROP_TICKS) : 1;

  state_t                        state_q, state_d;
  logic [ROWS-1:0][COLS-1:0][1:0] board_q;
  logic [COLS-1:0]               play_prev;
  logic [2:0]                    col_q, land_q, cur_row_q;
  logic [TW-1:0]                 tick_q;
  logic                          turn_q, invalid_q;

  logic                          press, tick_last;
  logic                          start, reject, commit, flip;
  col_sel_t                      sel;
  cell_t                         piece;

  logic [COLS-1:0][ROWS-1:0][1:0] col_cells;
  logic [COLS-1:0][2:0]           land_row;
  logic [COLS-1:0]                col_full;

  // Column-major view of the stored board, one landing finder per column.
  for (genvar c = 0; c < COLS; c++) begin : g_col
    for (genvar r = 0; r < ROWS; r++) begin : g_row
      assign col_cells[c][r] = board_q[r][c];
    end
    score4_land_row u_land (
      .cells    (col_cells[c]),
      .row      (land_row[c]),
      .col_full (col_full[c])
    );
  end

  assign press     = (play & ~play_prev) != '0;
  assign sel       = onehot_idx(play);
  assign tick_last = (tick_q == TW'(DROP_TICKS - 1));
  assign piece     = turn_q ? GREEN : RED;

  // State register; only rst is handled here, new_game comes through state_d.
  always_ff @(posedge clk) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  // Next state and the per-cycle action strobes.
  always_comb begin
    state_d = state_q;
    start   = 1'b0;
    reject  = 1'b0;
    commit  = 1'b0;
    flip    = 1'b0;
    case (state_q)
      IDLE: begin
        if (press) begin
          if (!sel.vld || col_full[sel.idx]) begin
            reject = 1'b1;
          end else begin
            start   = 1'b1;
            state_d = DROP;
          end
        end
      end
      DROP: begin
        if (tick_last && (cur_row_q == land_q)) begin
          commit  = 1'b1;
          state_d = CHECK;
        end
      end
      CHECK: begin
        // Board was committed last edge, so the checker flags reflect it now.
        if (win_a || win_b || full_panel) begin
          state_d = OVER;
        end else begin
          flip    = 1'b1;
          state_d = IDLE;
        end
      end
      OVER: ;
      default: state_d = IDLE;
    endcase
    if (new_game) begin
      state_d = IDLE;
      start   = 1'b0;
      reject  = 1'b0;
      commit  = 1'b0;
      flip    = 1'b0;
    end
  end

  // Board, drop position, turn and press-edge history.
  always_ff @(posedge clk) begin
    if (!rst) begin
      board_q   <= '0;
      play_prev <= '1;
      col_q     <= '0;
      land_q    <= '0;
      cur_row_q <= '0;
      tick_q    <= '0;
      turn_q    <= 1'b0;
      invalid_q <= 1'b0;
    end else if (new_game) begin
      board_q   <= '0;
      play_prev <= play;
      tick_q    <= '0;
      turn_q    <= 1'b0;
      invalid_q <= 1'b0;
    end else begin
      play_prev <= play;
      invalid_q <= reject;
      if (start) begin
        col_q     <= sel.idx;
        land_q    <= land_row[sel.idx];
        cur_row_q <= 3'(ROWS - 1);
        tick_q    <= '0;
      end else if (state_q == DROP) begin
        if (tick_last) begin
          tick_q <= '0;
          if (cur_row_q != land_q) cur_row_q <= cur_row_q - 3'd1;
        end else begin
          tick_q <= tick_q + TW'(1);
        end
      end
      if (commit) board_q[land_q][col_q] <= piece;
      if (flip)   turn_q <= ~turn_q;
    end
  end

  // Display view: stored board plus the falling piece while dropping.
  always_comb begin
    panel = board_q;
    if (state_q == DROP) panel[cur_row_q][col_q] = piece;
  end

  assign turn      = turn_q;
  assign busy      = (state_q == DROP) || (state_q == CHECK);
  assign game_over = (state_q == OVER);
  assign invalid   = invalid_q;

endmodule
